// File: rtl/demux_1x4_scheduler.sv
// Sequencer for a two-level 1-to-4 demux tree: accepts words via valid/ready,
// routes each to one channel (directed or round-robin), holds until delivered.
module demux_1x4_scheduler #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DROP_W = 8
) (
   input  logic              in_clk,
   input  logic              in_rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              out_ready,
   input  logic              in_mode,
   input  logic [1:0]        in_dest,
   input  logic [3:0]        in_enable,
   input  logic              in_ready_y1,
   input  logic              in_ready_y2,
   input  logic              in_ready_y3,
   input  logic              in_ready_y4,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid_y1,
   output logic              out_valid_y2,
   output logic              out_valid_y3,
   output logic              out_valid_y4,
   output logic              out_selec0,
   output logic              out_selec1,
   output logic              out_busy,
   output logic [DROP_W-1:0] out_drop_cnt
);

   typedef enum logic {StIdle, StHold} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [3:0]        valid_q, valid_d;
   logic [1:0]        k_q, k_d;
   logic [1:0]        ptr_q, ptr_d;
   logic              busy_q, busy_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic [3:0] ready_vec;
   logic       complete, accept;
   logic       rr_found, tgt_ok;
   logic [1:0] ptr_eff, rr_k, tgt_k, idx;

   assign ready_vec = {in_ready_y4, in_ready_y3, in_ready_y2, in_ready_y1};
   assign complete  = (state_q == StHold) & ready_vec[k_q];
   assign out_ready = (state_q == StIdle) | ready_vec[k_q];
   assign accept    = in_valid & out_ready;

   // A delivery on this edge advances the pointer before the new word is scanned,
   // so back-to-back round-robin traffic rotates without repeating a channel.
   always_comb begin
      ptr_eff  = complete ? k_q + 2'd1 : ptr_q;
      rr_found = 1'b0;
      rr_k     = ptr_eff;
      idx      = ptr_eff;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr_eff + 2'(i);
         if (in_enable[idx]) begin
            rr_found = 1'b1;
            rr_k     = idx;
         end
      end
   end

   assign tgt_k  = in_mode ? in_dest : rr_k;
   assign tgt_ok = in_mode ? in_enable[in_dest] : rr_found;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;
      k_d     = k_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      drop_d  = drop_q;

      if (complete) begin
         ptr_d   = k_q + 2'd1;
         state_d = StIdle;
         data_d  = '0;
         valid_d = '0;
         k_d     = '0;
         busy_d  = 1'b0;
      end

      if (accept) begin
         if (tgt_ok) begin
            state_d = StHold;
            data_d  = in_data;
            valid_d = 4'b0001 << tgt_k;
            k_d     = tgt_k;
            busy_d  = 1'b1;
         end else if (drop_q != {DROP_W{1'b1}}) begin
            drop_d = drop_q + DROP_W'(1);
         end
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q <= StIdle;
         data_q  <= '0;
         valid_q <= '0;
         k_q     <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         k_q     <= k_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
      end
   end

   assign out_data     = data_q;
   assign out_valid_y1 = valid_q[0];
   assign out_valid_y2 = valid_q[1];
   assign out_valid_y3 = valid_q[2];
   assign out_valid_y4 = valid_q[3];
   assign out_selec0   = k_q[1];
   assign out_selec1   = k_q[0];
   assign out_busy     = busy_q;
   assign out_drop_cnt = drop_q;

endmodule

// File: tb/tb_demux_1x4_scheduler.sv
// Bench for demux_1x4_scheduler: transaction-level model compared every cycle,
// plus literal expectations on delivery order, drop counts and reset behaviour.
module tb_demux_1x4_scheduler;

   localparam int DATA_W   = 8;
   localparam int DROP_W   = 8;
   localparam int DROP_MAX = (1 << DROP_W) - 1;

   logic              in_clk = 1'b0;
   logic              in_rst_n = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_mode = 1'b0;
   logic [1:0]        in_dest = '0;
   logic [3:0]        in_enable = '0;
   logic [3:0]        rdy = '0;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid_y1, out_valid_y2, out_valid_y3, out_valid_y4;
   logic              out_selec0, out_selec1, out_busy;
   logic [DROP_W-1:0] out_drop_cnt;

   demux_1x4_scheduler #(.DATA_W(DATA_W), .DROP_W(DROP_W)) dut (
      .in_clk       (in_clk),
      .in_rst_n     (in_rst_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .out_ready    (out_ready),
      .in_mode      (in_mode),
      .in_dest      (in_dest),
      .in_enable    (in_enable),
      .in_ready_y1  (rdy[0]),
      .in_ready_y2  (rdy[1]),
      .in_ready_y3  (rdy[2]),
      .in_ready_y4  (rdy[3]),
      .out_data     (out_data),
      .out_valid_y1 (out_valid_y1),
      .out_valid_y2 (out_valid_y2),
      .out_valid_y3 (out_valid_y3),
      .out_valid_y4 (out_valid_y4),
      .out_selec0   (out_selec0),
      .out_selec1   (out_selec1),
      .out_busy     (out_busy),
      .out_drop_cnt (out_drop_cnt)
   );

   always #5 in_clk = ~in_clk;

   int errors = 0;
   int checks = 0;

   // Model: at most one held word with its channel, a pointer, a drop tally.
   bit                m_held = 1'b0;
   int                m_k = 0;
   int                m_ptr = 0;
   int                m_drops = 0;
   logic [DATA_W-1:0] m_data = '0;

   int                dlv_ch[$];
   logic [DATA_W-1:0] dlv_data[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge in_clk or negedge in_rst_n) begin : model_upd
      bit ready, acc, ok;
      int p, k;
      if (!in_rst_n) begin
         m_held  = 1'b0;
         m_k     = 0;
         m_ptr   = 0;
         m_drops = 0;
         m_data  = '0;
      end else begin
         ready = !m_held || rdy[m_k];
         acc   = in_valid && ready;
         if (m_held && rdy[m_k]) begin
            m_ptr  = (m_k + 1) % 4;
            m_held = 1'b0;
            m_k    = 0;
            m_data = '0;
         end
         if (acc) begin
            p  = m_ptr;
            ok = 1'b0;
            k  = 0;
            if (in_mode) begin
               k  = int'(in_dest);
               ok = in_enable[k];
            end else begin
               for (int off = 0; off < 4; off++) begin
                  if (!ok && in_enable[(p + off) % 4]) begin
                     ok = 1'b1;
                     k  = (p + off) % 4;
                  end
               end
            end
            if (ok) begin
               m_held = 1'b1;
               m_k    = k;
               m_data = in_data;
            end else if (m_drops < DROP_MAX) begin
               m_drops++;
            end
         end
      end
   end

   always @(negedge in_clk) begin : compare
      logic [3:0] exp_valid, act_valid;
      exp_valid = m_held ? (4'b0001 << m_k) : 4'b0000;
      act_valid = {out_valid_y4, out_valid_y3, out_valid_y2, out_valid_y1};
      check("valid", 32'(act_valid), 32'(exp_valid));
      check("data", 32'(out_data), m_held ? 32'(m_data) : 32'h0);
      check("selec0", 32'(out_selec0), m_held ? 32'((m_k >> 1) & 1) : 32'h0);
      check("selec1", 32'(out_selec1), m_held ? 32'(m_k & 1) : 32'h0);
      check("busy", 32'(out_busy), 32'(m_held));
      check("drop_cnt", 32'(out_drop_cnt), 32'(m_drops));
      check("ready", 32'(out_ready), 32'(!m_held || rdy[m_k]));
      if (in_rst_n) begin
         for (int c = 0; c < 4; c++) begin
            if (act_valid[c] && rdy[c]) begin
               dlv_ch.push_back(c);
               dlv_data.push_back(out_data);
            end
         end
      end
   end

   task automatic cyc(input logic v, input logic [7:0] d, input logic mode, input logic [1:0] dest,
                      input logic [3:0] en, input logic [3:0] r);
      in_valid  = v;
      in_data   = d;
      in_mode   = mode;
      in_dest   = dest;
      in_enable = en;
      rdy       = r;
      @(posedge in_clk);
      #1;
   endtask

   task automatic check_dlv(input string name, input int n, input int ch[6], input int dat[6]);
      check({name, "_count"}, 32'(dlv_ch.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         check({name, "_ch"}, (i < dlv_ch.size()) ? 32'(dlv_ch[i]) : 32'hffff, 32'(ch[i]));
         if (dat[i] >= 0)
            check({name, "_data"}, (i < dlv_data.size()) ? 32'(dlv_data[i]) : 32'hffff,
                  32'(dat[i]));
      end
   endtask

   initial begin
      repeat (2) @(posedge in_clk);
      #1;
      in_rst_n = 1'b1;
      cyc(0, 8'h00, 1, 0, 4'hF, 4'hF);

      // Directed to y1..y4 in order
      dlv_ch.delete(); dlv_data.delete();
      for (int i = 0; i < 4; i++) cyc(1, 8'hA1 + 8'(i), 1, 2'(i), 4'hF, 4'hF);
      cyc(0, 8'h00, 1, 0, 4'hF, 4'hF);
      cyc(0, 8'h00, 1, 0, 4'hF, 4'hF);
      check_dlv("directed", 4, '{0, 1, 2, 3, 0, 0}, '{'hA1, 'hA2, 'hA3, 'hA4, 0, 0});

      // Round-robin over y1, y2, y4
      dlv_ch.delete(); dlv_data.delete();
      for (int i = 0; i < 6; i++) cyc(1, 8'hB0 + 8'(i), 0, 0, 4'b1011, 4'hF);
      cyc(0, 8'h00, 0, 0, 4'b1011, 4'hF);
      cyc(0, 8'h00, 0, 0, 4'b1011, 4'hF);
      check_dlv("rr", 6, '{0, 1, 3, 0, 1, 3}, '{'hB0, 'hB1, 'hB2, 'hB3, 'hB4, 'hB5});
      check("rr_drop_lit", 32'(out_drop_cnt), 32'd0);

      // Drops: disabled directed target, then empty enable mask
      dlv_ch.delete(); dlv_data.delete();
      cyc(1, 8'hC0, 1, 2, 4'b1011, 4'hF);
      for (int i = 0; i < 3; i++) cyc(1, 8'hC1 + 8'(i), 0, 0, 4'b0000, 4'hF);
      cyc(0, 8'h00, 0, 0, 4'b0000, 4'hF);
      check("drop_lit", 32'(out_drop_cnt), 32'd4);
      check("drop_no_dlv", 32'(dlv_ch.size()), 32'd0);

      // Backpressure on y3, enable toggled while held
      dlv_ch.delete(); dlv_data.delete();
      cyc(1, 8'h5C, 1, 2, 4'hF, 4'b1011);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 8'h5D, 1, 0, (i % 2 == 0) ? 4'b0000 : 4'b1111, 4'b1011);
         check("bp_valid_lit", 32'(out_valid_y3), 32'd1);
         check("bp_data_lit", 32'(out_data), 32'h5C);
         check("bp_ready_lit", 32'(out_ready), 32'd0);
      end
      cyc(1, 8'h5D, 1, 0, 4'hF, 4'hF);
      check("bp_next_data_lit", 32'(out_data), 32'h5D);
      check("bp_next_valid_lit", 32'(out_valid_y1), 32'd1);
      cyc(0, 8'h00, 1, 0, 4'hF, 4'hF);
      cyc(0, 8'h00, 1, 0, 4'hF, 4'hF);
      check_dlv("bp", 2, '{2, 0, 0, 0, 0, 0}, '{'h5C, 'h5D, 0, 0, 0, 0});

      // Saturation of the drop counter
      for (int i = 0; i < 300; i++) cyc(1, 8'(i), 1, 0, 4'b0000, 4'hF);
      cyc(0, 8'h00, 1, 0, 4'hF, 4'hF);
      check("sat_lit", 32'(out_drop_cnt), 32'd255);

      // Reset during HOLD, pointer sitting at y3
      dlv_ch.delete(); dlv_data.delete();
      cyc(1, 8'h11, 0, 0, 4'hF, 4'hF);
      cyc(1, 8'h22, 0, 0, 4'hF, 4'b1011);
      cyc(0, 8'h00, 0, 0, 4'hF, 4'b1011);
      check("pre_rst_valid_lit", 32'(out_valid_y3), 32'd1);
      check_dlv("pre_rst", 1, '{1, 0, 0, 0, 0, 0}, '{'h11, 0, 0, 0, 0, 0});
      #2;
      in_rst_n = 1'b0;
      #1;
      check("rst_valid_lit", 32'({out_valid_y4, out_valid_y3, out_valid_y2, out_valid_y1}), 32'd0);
      check("rst_data_lit", 32'(out_data), 32'd0);
      check("rst_busy_lit", 32'(out_busy), 32'd0);
      check("rst_sel_lit", 32'({out_selec0, out_selec1}), 32'd0);
      check("rst_drop_lit", 32'(out_drop_cnt), 32'd0);
      check("rst_ready_lit", 32'(out_ready), 32'd1);
      @(posedge in_clk);
      #1;
      in_rst_n = 1'b1;
      dlv_ch.delete(); dlv_data.delete();
      cyc(1, 8'h33, 0, 0, 4'hF, 4'hF);
      cyc(0, 8'h00, 0, 0, 4'hF, 4'hF);
      cyc(0, 8'h00, 0, 0, 4'hF, 4'hF);
      check_dlv("post_rst", 1, '{0, 0, 0, 0, 0, 0}, '{'h33, 0, 0, 0, 0, 0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
